// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder
// Receive end of an XOR-keystream link. Encoded words z = x ^ key arrive on
// the input handshake. A Galois LFSR regenerates the upstream keystream, and
// the recovered word x = z ^ key is held in one registered output stage.
// The stage sustains one word per clock. The keystream advances only when a
// word is accepted. seed_load resynchronises the keystream and flushes the
// output stage.
//
// Optional feature, selected by the macro XOR_DEC_PARITY_EN:
//   Defining the macro adds the in_parity input and the sticky par_err output.
//   These check the even parity of each recovered word against the parity
//   computed upstream.
//   Leaving the macro undefined builds neither the ports nor the parity logic.

module xor_stream_decoder #(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           word_cnt
`ifdef XOR_DEC_PARITY_EN
  ,
  input  logic                  in_parity,
  output logic                  par_err
`endif
);

  // One Galois step: shift right, then fold in the taps when the bit that
  // leaves the register is 1.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] state);
    logic [LFSR_WIDTH-1:0] nxt;
    nxt = state >> 1;
    if (state[0] == 1'b1) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // A zero seed would lock the LFSR at zero forever, so it is replaced with
  // the reset seed.
  function automatic logic [LFSR_WIDTH-1:0] seed_fix(input logic [LFSR_WIDTH-1:0] seed);
    logic [LFSR_WIDTH-1:0] res;
    if (seed == {LFSR_WIDTH{1'b0}}) begin
      res = LFSR_SEED;
    end else begin
      res = seed;
    end
    return res;
  endfunction

`ifdef XOR_DEC_PARITY_EN
  // Even parity of a data word. The result is 1 when the word has an odd
  // number of 1 bits.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [15:0]           r_word_cnt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_key;
  logic [DATA_WIDTH-1:0] w_plain;
  logic [LFSR_WIDTH-1:0] w_lfsr_next;
  logic [LFSR_WIDTH-1:0] w_seed_sel;

  // Handshake and decode datapath. in_ready does not depend on in_valid, so
  // no combinational loop can form through an upstream valid that waits on
  // ready.
  always_comb begin
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_key       = {DATA_WIDTH{1'b0}};
    w_plain     = {DATA_WIDTH{1'b0}};
    w_lfsr_next = {LFSR_WIDTH{1'b0}};
    w_seed_sel  = {LFSR_WIDTH{1'b0}};
    if (seed_load == 1'b1) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = (~r_out_valid) | out_ready;
    end
    w_accept    = in_valid & w_in_ready;
    w_key       = r_lfsr[DATA_WIDTH-1:0];
    w_plain     = in_data ^ w_key;
    w_lfsr_next = lfsr_step(r_lfsr);
    w_seed_sel  = seed_fix(seed_in);
  end

  // Keystream state, the output stage and the accepted-word counter.
  // seed_load outranks an accept; an accept outranks draining the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr      <= LFSR_SEED;
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
      r_word_cnt  <= 16'h0000;
    end else if (seed_load) begin
      r_lfsr      <= w_seed_sel;
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
      r_word_cnt  <= 16'h0000;
    end else if (w_accept) begin
      r_lfsr      <= w_lfsr_next;
      r_out_valid <= 1'b1;
      r_out_data  <= w_plain;
      r_word_cnt  <= r_word_cnt + 16'h0001;
    end else if (out_ready) begin
      r_lfsr      <= r_lfsr;
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
      r_word_cnt  <= r_word_cnt;
    end else begin
      r_lfsr      <= r_lfsr;
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_word_cnt  <= r_word_cnt;
    end
  end

`ifdef XOR_DEC_PARITY_EN
  logic r_par_err;

  // Sticky parity error. It sets on an accepted word whose recovered parity
  // disagrees with in_parity. Only reset or a resync clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par_err <= 1'b0;
    end else if (seed_load) begin
      r_par_err <= 1'b0;
    end else if (w_accept && (even_parity(w_plain) != in_parity)) begin
      r_par_err <= 1'b1;
    end else begin
      r_par_err <= r_par_err;
    end
  end

  assign par_err = r_par_err;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign word_cnt  = r_word_cnt;

endmodule
